max_pool_reduce: RTL and testbench

Consumes the sample stream fetched at the addresses produced by the max-pool address generator, which emits four addresses per 2×2 window. Reduces each group of four consecutive samples to its signed maximum. Writes one result per window, together with a sequential output-buffer address, over a valid/ready handshake. Sits between the feature-map read port and the pooled-map write port; one frame is (matrix_size-1)² windows.

---
 rtl/max_pool_reduce_pkg.sv | 31 +++
 rtl/max_pool_reduce_acc.sv | 58 +++++
 rtl/max_pool_reduce.sv | 133 +++++++++++++
 tb/tb_max_pool_reduce.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_reduce_pkg.sv
// Shared definitions for the max-pool reduction path: FSM encoding,
// per-frame window count and the signed-max helper used by pooling blocks.
package max_pool_reduce_pkg;

    localparam int unsigned MATRIX_SIZE = 24;
    localparam int unsigned ADD_SIZE    = 20;
    localparam int unsigned DATA_WIDTH  = 16;

    // Common operand width of smax; callers sign-extend into it.
    localparam int unsigned SMAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned win_count(input int unsigned ms);
        return (ms - 32'd1) * (ms - 32'd1);
    endfunction

    localparam int unsigned WIN_COUNT = win_count(MATRIX_SIZE);

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_reduce_acc.sv
// Phase counter and running signed maximum over one 2x2 window of four
// consecutive samples; flags the accepted sample that completes a window.
module max_pool_acc
    import max_pool_reduce_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [data_width-1:0] sample_i,
    output logic                  window_done_o,
    output logic [data_width-1:0] window_max_o
);

    logic [1:0]                   phase_q;
    logic [1:0]                   phase_d;
    logic signed [data_width-1:0] acc_q;
    logic signed [data_width-1:0] acc_d;
    logic signed [data_width-1:0] sample_s;

    assign sample_s      = sample_i;
    assign window_max_o  = data_width'(smax(SMAX_W'(acc_q), SMAX_W'(sample_s)));
    assign window_done_o = accept_i && (phase_q == 2'd3);

    // Next phase and accumulator: phase 0 loads, later phases fold in the max.
    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        if (clear_i) begin
            phase_d = 2'd0;
            acc_d   = {data_width{1'b0}};
        end else if (accept_i) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd0) begin
                acc_d = sample_s;
            end else begin
                acc_d = window_max_o;
            end
        end else begin
            phase_d = phase_q;
            acc_d   = acc_q;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 2'd0;
            acc_q   <= {data_width{1'b0}};
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/max_pool_reduce.sv
// Reduces each group of four samples to its signed maximum and writes one
// result per window to base + window index over a valid/ready handshake.
module max_pool_reduce
    import max_pool_reduce_pkg::*;
#(
    parameter int unsigned matrix_size = MATRIX_SIZE,
    parameter int unsigned add_size    = ADD_SIZE,
    parameter int unsigned data_width  = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [add_size-1:0]   out_base,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic [add_size-1:0]   out_add,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned WIN_TOTAL =
        (matrix_size == MATRIX_SIZE) ? WIN_COUNT : win_count(matrix_size);
    localparam logic [add_size-1:0] WIN_LAST = add_size'(WIN_TOTAL - 32'd1);

    state_e                state_q, state_d;
    logic [add_size-1:0]   base_q, base_d;
    logic [add_size-1:0]   win_q, win_d;
    logic                  last_q, last_d;
    logic                  out_valid_q, out_valid_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic [add_size-1:0]   out_add_q, out_add_d;
    logic                  acc_clear_s;
    logic                  accept_s;
    logic                  win_done_s;
    logic [data_width-1:0] win_max_s;

    // last_q blocks intake once the final window is loaded so nothing spills into the next frame.
    assign in_ready  = (state_q == ST_RUN) && !last_q && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_add   = out_add_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

    max_pool_acc #(
        .data_width (data_width)
    ) u_acc (
        .clk_i         (clk),
        .rst_ni        (reset),
        .clear_i       (acc_clear_s),
        .accept_i      (accept_s),
        .sample_i      (in_data),
        .window_done_o (win_done_s),
        .window_max_o  (win_max_s)
    );

    // Next-state and output-register logic; loading a result wins over draining it.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        win_d       = win_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_add_d   = out_add_q;
        acc_clear_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    base_d      = out_base;
                    win_d       = {add_size{1'b0}};
                    last_d      = 1'b0;
                    acc_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (win_done_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = win_max_s;
                    out_add_d   = base_q + win_q;
                    win_d       = win_q + {{(add_size-1){1'b0}}, 1'b1};
                    if (win_q == WIN_LAST) begin
                        last_d = 1'b1;
                    end else begin
                        last_d = last_q;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            base_q      <= {add_size{1'b0}};
            win_q       <= {add_size{1'b0}};
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {data_width{1'b0}};
            out_add_q   <= {add_size{1'b0}};
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            win_q       <= win_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_add_q   <= out_add_d;
        end
    end

endmodule

// File: tb/tb_max_pool_reduce.sv
// Directed bench for max_pool_reduce with a 4x4 feature map (9 windows per frame).
module tb_max_pool_reduce;

    localparam int MS   = 4;
    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int NWIN = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] out_base = 20'h0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = 16'h0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_add;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] res_data[$];
    logic [AW-1:0] res_add[$];
    int stim_q[$];

    max_pool_reduce #(
        .matrix_size (MS),
        .add_size    (AW),
        .data_width  (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .out_base  (out_base),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_add   (out_add),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Record every result that will transfer at the coming rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            res_data.push_back(out_data);
            res_add.push_back(out_add);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset    = 1'b0;
        #2;
        reset    = 1'b1;
        step(1);
        res_data.delete();
        res_add.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        start    = 1'b1;
        out_base = base;
        step(1);
        start    = 1'b0;
    endtask

    task automatic fill_seq(input int first, input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(first + i);
    endtask

    task automatic feed(input bit gaps, input int budget, output int fed);
        int idx = 0;
        int cyc = 0;
        bit took;
        while (idx < stim_q.size() && cyc < budget) begin
            in_valid = (gaps && ($urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
            in_data  = 16'(stim_q[idx]);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        fed = idx;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_add !== 20'h0) begin errors++; $display("FAIL reset_out_add got=%h exp=0", out_add); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        step(1);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_stream();
        int fed;
        do_reset();
        do_start(20'h100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready got=%b exp=1", in_ready); end
        fill_seq(1, 36);
        feed(1'b0, 200, fed);
        checks++; if (fed !== 36) begin errors++; $display("FAIL stream_fed got=%0d exp=36", fed); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL last_in_ready got=%b exp=0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pre_done got=%b exp=0", done); end
        step(1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stream_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_out_valid got=%b exp=0", out_valid); end
        checks++; if (res_data.size() !== NWIN) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", res_data.size(), NWIN); end
        for (int k = 0; k < NWIN && k < res_data.size(); k++) begin
            checks++; if (res_data[k] !== 16'(4 * (k + 1))) begin errors++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", k, res_data[k], 4 * (k + 1)); end
            checks++; if (res_add[k] !== 20'h100 + 20'(k)) begin errors++; $display("FAIL stream_add[%0d] got=%h exp=%h", k, res_add[k], 20'h100 + 20'(k)); end
        end
    endtask

    task automatic test_signed();
        int fed;
        logic [DW-1:0] exp_q[$];
        do_reset();
        do_start(20'h0);
        stim_q = '{-5, -1, -32768, -2};
        feed(1'b0, 50, fed);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL signed_neg got=%h exp=ffff", out_data); end
        stim_q = '{32767, -32768, 0, 0, -32768, -32768, -32768, -32768,
                   5, 5, 5, 5, 65535, 32768, 65535, 0};
        feed(1'b0, 100, fed);
        checks++; if (fed !== 16) begin errors++; $display("FAIL signed_fed got=%0d exp=16", fed); end
        step(2);
        exp_q = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0000};
        checks++; if (res_data.size() !== 5) begin errors++; $display("FAIL signed_count got=%0d exp=5", res_data.size()); end
        for (int k = 0; k < 5 && k < res_data.size(); k++) begin
            checks++; if (res_data[k] !== exp_q[k]) begin errors++; $display("FAIL signed_data[%0d] got=%h exp=%h", k, res_data[k], exp_q[k]); end
            checks++; if (res_add[k] !== 20'(k)) begin errors++; $display("FAIL signed_add[%0d] got=%h exp=%h", k, res_add[k], 20'(k)); end
        end
    endtask

    task automatic test_stall();
        int fed;
        do_reset();
        do_start(20'h100);
        out_ready = 1'b0;
        fill_seq(1, 4);
        feed(1'b0, 50, fed);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'd5;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", c, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, out_valid); end
            checks++; if (out_data !== 16'd4) begin errors++; $display("FAIL stall_data[%0d] got=%0d exp=4", c, out_data); end
            checks++; if (out_add !== 20'h100) begin errors++; $display("FAIL stall_add[%0d] got=%h exp=100", c, out_add); end
            step(1);
        end
        out_ready = 1'b1;
        fill_seq(5, 32);
        feed(1'b0, 200, fed);
        checks++; if (fed !== 32) begin errors++; $display("FAIL stall_fed got=%0d exp=32", fed); end
        step(1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got=%b exp=1", done); end
        checks++; if (res_data.size() !== NWIN) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", res_data.size(), NWIN); end
        for (int k = 0; k < NWIN && k < res_data.size(); k++) begin
            checks++; if (res_data[k] !== 16'(4 * (k + 1))) begin errors++; $display("FAIL stall_res[%0d] got=%0d exp=%0d", k, res_data[k], 4 * (k + 1)); end
            checks++; if (res_add[k] !== 20'h100 + 20'(k)) begin errors++; $display("FAIL stall_res_add[%0d] got=%h exp=%h", k, res_add[k], 20'h100 + 20'(k)); end
        end
    endtask

    task automatic test_gaps();
        int fed;
        do_reset();
        do_start(20'h100);
        fill_seq(1, 36);
        feed(1'b1, 600, fed);
        checks++; if (fed !== 36) begin errors++; $display("FAIL gaps_fed got=%0d exp=36", fed); end
        step(2);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done got=%b exp=1", done); end
        checks++; if (res_data.size() !== NWIN) begin errors++; $display("FAIL gaps_count got=%0d exp=%0d", res_data.size(), NWIN); end
        for (int k = 0; k < NWIN && k < res_data.size(); k++) begin
            checks++; if (res_data[k] !== 16'(4 * (k + 1))) begin errors++; $display("FAIL gaps_data[%0d] got=%0d exp=%0d", k, res_data[k], 4 * (k + 1)); end
            checks++; if (res_add[k] !== 20'h100 + 20'(k)) begin errors++; $display("FAIL gaps_add[%0d] got=%h exp=%h", k, res_add[k], 20'h100 + 20'(k)); end
        end
    endtask

    task automatic test_async_reset();
        int fed;
        do_reset();
        do_start(20'h100);
        fill_seq(1, 6);
        feed(1'b0, 50, fed);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
        checks++; if (out_data !== 16'd4) begin errors++; $display("FAIL mid_data got=%0d exp=4", out_data); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL areset_data got=%h exp=0", out_data); end
        checks++; if (out_add !== 20'h0) begin errors++; $display("FAIL areset_add got=%h exp=0", out_add); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", done); end
        step(1);
        reset = 1'b1;
        step(1);
        do_start(20'h200);
        fill_seq(7, 4);
        feed(1'b0, 50, fed);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'd10) begin errors++; $display("FAIL restart_data got=%0d exp=10", out_data); end
        checks++; if (out_add !== 20'h200) begin errors++; $display("FAIL restart_add got=%h exp=200", out_add); end
    endtask

    task automatic test_start_ctrl();
        int fed;
        do_reset();
        do_start(20'h100);
        fill_seq(1, 4);
        feed(1'b0, 50, fed);
        do_start(20'h300);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_start_busy got=%b exp=1", busy); end
        fill_seq(5, 32);
        feed(1'b0, 200, fed);
        step(1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_start_done got=%b exp=1", done); end
        checks++; if (res_data.size() !== NWIN) begin errors++; $display("FAIL run_start_count got=%0d exp=%0d", res_data.size(), NWIN); end
        for (int k = 0; k < NWIN && k < res_data.size(); k++) begin
            checks++; if (res_data[k] !== 16'(4 * (k + 1))) begin errors++; $display("FAIL run_start_data[%0d] got=%0d exp=%0d", k, res_data[k], 4 * (k + 1)); end
            checks++; if (res_add[k] !== 20'h100 + 20'(k)) begin errors++; $display("FAIL run_start_add[%0d] got=%h exp=%h", k, res_add[k], 20'h100 + 20'(k)); end
        end
        res_data.delete();
        res_add.delete();
        do_start(20'h400);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rerun_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rerun_busy got=%b exp=1", busy); end
        stim_q.delete();
        for (int i = 1; i <= 36; i++) stim_q.push_back(-i);
        feed(1'b0, 200, fed);
        step(1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_end_done got=%b exp=1", done); end
        checks++; if (res_data.size() !== NWIN) begin errors++; $display("FAIL rerun_count got=%0d exp=%0d", res_data.size(), NWIN); end
        for (int k = 0; k < NWIN && k < res_data.size(); k++) begin
            checks++; if (res_data[k] !== 16'(-(4 * k + 1))) begin errors++; $display("FAIL rerun_data[%0d] got=%h exp=%h", k, res_data[k], 16'(-(4 * k + 1))); end
            checks++; if (res_add[k] !== 20'h400 + 20'(k)) begin errors++; $display("FAIL rerun_add[%0d] got=%h exp=%h", k, res_add[k], 20'h400 + 20'(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_signed();
        test_stall();
        test_gaps();
        test_async_reset();
        test_start_ctrl();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
